// File: rtl/out_port_fifo.sv
// First-word fall-through queue between the processor output port and an external
// valid/ready consumer; counts and flags writes dropped while the queue is full.
module out_port_fifo #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DROP_W = 8
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              clear,
    input  logic [DATA_W-1:0] proc_data,
    input  logic              proc_wr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              full,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   FULL_LEVEL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   ONE_LEVEL  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ONE_PTR    = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DROP_W-1:0] DROP_MAX   = {DROP_W{1'b1}};
    localparam logic [DROP_W-1:0] DROP_ONE   = {{(DROP_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   level_r;
    logic [ADDR_W:0]   level_nxt_s;
    logic              valid_r;
    logic              full_r;
    logic              overflow_r;
    logic [DROP_W-1:0] drop_r;
    logic              push_s;
    logic              pop_s;
    logic              drop_s;

    assign pop_s  = valid_r & out_ready;
    assign push_s = proc_wr & (~full_r | pop_s);
    assign drop_s = proc_wr & full_r & ~pop_s;

    // Next occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        level_nxt_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + ONE_LEVEL;
            2'b01:   level_nxt_s = level_r - ONE_LEVEL;
            default: level_nxt_s = level_r;
        endcase
    end

    // Pointers, occupancy, status flags and drop accounting.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= {ADDR_W{1'b0}};
            rd_ptr_r   <= {ADDR_W{1'b0}};
            level_r    <= {(ADDR_W+1){1'b0}};
            valid_r    <= 1'b0;
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
            drop_r     <= {DROP_W{1'b0}};
        end else if (clear) begin
            wr_ptr_r   <= {ADDR_W{1'b0}};
            rd_ptr_r   <= {ADDR_W{1'b0}};
            level_r    <= {(ADDR_W+1){1'b0}};
            valid_r    <= 1'b0;
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
            drop_r     <= {DROP_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_PTR;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_PTR;
            end
            level_r <= level_nxt_s;
            valid_r <= (level_nxt_s != {(ADDR_W+1){1'b0}});
            full_r  <= (level_nxt_s == FULL_LEVEL);
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_r != DROP_MAX) begin
                    drop_r <= drop_r + DROP_ONE;
                end
            end
        end
    end

    // Storage array is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (push_s && !clear && !rst) begin
            mem_r[wr_ptr_r] <= proc_data;
        end
    end

    assign out_data   = valid_r ? mem_r[rd_ptr_r] : {DATA_W{1'b0}};
    assign out_valid  = valid_r;
    assign full       = full_r;
    assign level      = level_r;
    assign overflow   = overflow_r;
    assign drop_count = drop_r;

endmodule
